divider_cfg_ctrl: RTL and testbench

- Upstream sequencer for the N-divider.
- Accepts divisor-change requests on a valid/ready handshake and waits for a safe point, where div_clk is low.
- Then drives the divider's enable, active-high reset and N inputs through a disable → reset → reload → restart sequence.
- This removes hand-sequenced rst/en/N pokes and prevents runt div_clk pulses during reconfiguration.

---
 rtl/divider_cfg_ctrl_pkg.sv | 15 +
 rtl/divider_cfg_ctrl.sv | 97 +++++++++
 tb/tb_divider_cfg_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/divider_cfg_ctrl_pkg.sv
// rtl/divider_cfg_ctrl_pkg.sv - shared width default and state encoding for the divider sequencer
package divider_cfg_ctrl_pkg;

  localparam int SIZE_DEFAULT = 4;

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_IDLE     = 3'd1,
    ST_WAIT_LOW = 3'd2,
    ST_DISABLE  = 3'd3,
    ST_RESET    = 3'd4,
    ST_RESTART  = 3'd5
  } state_t;

endpackage

// File: rtl/divider_cfg_ctrl.sv
// rtl/divider_cfg_ctrl.sv - sequences disable/reset/reload/restart of the N-divider on a divisor change
module divider_cfg_ctrl
  import divider_cfg_ctrl_pkg::*;
#(
  parameter int SIZE       = SIZE_DEFAULT,
  parameter int DEFAULT_N  = 1,
  parameter int RST_CYCLES = 2,
  parameter int WAIT_MAX   = 16
) (
  input  logic            ref_clk,
  input  logic            reset,
  input  logic            cfg_valid,
  input  logic [SIZE-1:0] cfg_N,
  output logic            cfg_ready,
  output logic            cfg_err,
  input  logic            run,
  input  logic            div_clk,
  output logic [SIZE-1:0] div_N,
  output logic            div_enable,
  output logic            div_reset,
  output logic            busy,
  output logic            update_done
);

  localparam int WW = $clog2(WAIT_MAX) + 1;
  localparam int RW = $clog2(RST_CYCLES) + 1;
  localparam logic [WW-1:0]   WAIT_LAST = WW'(WAIT_MAX - 1);
  localparam logic [RW-1:0]   RST_LAST  = RW'(RST_CYCLES - 1);
  localparam logic [SIZE-1:0] N_RESET   = SIZE'(DEFAULT_N);

  state_t          state;
  state_t          next_state;
  logic [WW-1:0]   wait_cnt;
  logic [RW-1:0]   rst_cnt;
  logic [SIZE-1:0] pend_n;
  logic            take_cfg;
  logic            cfg_zero;

  // cfg_ready is registered to be high exactly while state is IDLE
  assign take_cfg = (state == ST_IDLE) && cfg_valid;
  assign cfg_zero = (cfg_N == '0);

  always_comb begin
    next_state = state;
    case (state)
      ST_INIT:     if (rst_cnt == RST_LAST) next_state = ST_IDLE;
      ST_IDLE:     if (take_cfg && !cfg_zero) next_state = ST_WAIT_LOW;
      ST_WAIT_LOW: if (!div_clk || (wait_cnt == WAIT_LAST)) next_state = ST_DISABLE;
      ST_DISABLE:  next_state = ST_RESET;
      ST_RESET:    if (rst_cnt == RST_LAST) next_state = ST_RESTART;
      ST_RESTART:  next_state = ST_IDLE;
      default:     next_state = ST_INIT;
    endcase
  end

  // Outputs decode next_state so they line up with the state they describe
  always_ff @(posedge ref_clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_INIT;
      wait_cnt    <= '0;
      rst_cnt     <= '0;
      pend_n      <= N_RESET;
      div_N       <= N_RESET;
      div_reset   <= 1'b1;
      div_enable  <= 1'b0;
      cfg_ready   <= 1'b0;
      cfg_err     <= 1'b0;
      update_done <= 1'b0;
      busy        <= 1'b1;
    end else begin
      state <= next_state;

      if ((state == ST_WAIT_LOW) && (next_state == ST_WAIT_LOW))
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;

      if ((next_state == state) && ((state == ST_INIT) || (state == ST_RESET)))
        rst_cnt <= rst_cnt + 1'b1;
      else
        rst_cnt <= '0;

      if (take_cfg && !cfg_zero)
        pend_n <= cfg_N;
      if ((state != ST_RESET) && (next_state == ST_RESET))
        div_N <= pend_n;

      div_reset   <= (next_state == ST_INIT) || (next_state == ST_RESET);
      div_enable  <= ((next_state == ST_IDLE) || (next_state == ST_WAIT_LOW)) && run;
      cfg_ready   <= (next_state == ST_IDLE);
      busy        <= (next_state != ST_IDLE);
      update_done <= (next_state == ST_RESTART);
      cfg_err     <= take_cfg && cfg_zero;
    end
  end

endmodule

// File: tb/tb_divider_cfg_ctrl.sv
// tb/tb_divider_cfg_ctrl.sv - directed self-checking bench for divider_cfg_ctrl
module tb_divider_cfg_ctrl;

  logic       ref_clk = 1'b0;
  logic       reset;
  logic       cfg_valid;
  logic [3:0] cfg_N;
  logic       cfg_ready;
  logic       cfg_err;
  logic       run;
  logic       div_clk;
  logic [3:0] div_N;
  logic       div_enable;
  logic       div_reset;
  logic       busy;
  logic       update_done;

  int checks = 0;
  int passes = 0;

  divider_cfg_ctrl #(
    .SIZE(4), .DEFAULT_N(1), .RST_CYCLES(2), .WAIT_MAX(16)
  ) dut (
    .ref_clk(ref_clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_N(cfg_N),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .run(run), .div_clk(div_clk),
    .div_N(div_N), .div_enable(div_enable), .div_reset(div_reset),
    .busy(busy), .update_done(update_done)
  );

  always #5 ref_clk = ~ref_clk;

  task automatic expect_eq(input string tag, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge ref_clk);
    @(negedge ref_clk);
  endtask

  int n;
  int dones;
  int accept_at;

  initial begin
    reset = 1'b0; run = 1'b1; cfg_valid = 1'b0; cfg_N = 4'd0; div_clk = 1'b0;
    tick(); tick();
    expect_eq("rst_div_reset", div_reset, 1);
    expect_eq("rst_div_enable", div_enable, 0);
    expect_eq("rst_div_N", div_N, 1);
    expect_eq("rst_cfg_ready", cfg_ready, 0);
    expect_eq("rst_busy", busy, 1);
    expect_eq("rst_update_done", update_done, 0);

    // Release: two INIT cycles then IDLE
    reset = 1'b1;
    tick();
    expect_eq("init_div_reset", div_reset, 1);
    expect_eq("init_cfg_ready", cfg_ready, 0);
    tick();
    expect_eq("idle_div_reset", div_reset, 0);
    expect_eq("idle_cfg_ready", cfg_ready, 1);
    expect_eq("idle_div_enable", div_enable, 1);
    expect_eq("idle_busy", busy, 0);
    expect_eq("idle_div_N", div_N, 1);

    // N=3 with div_clk already low: cycle-exact sequence
    cfg_valid = 1'b1; cfg_N = 4'd3;
    tick(); cfg_valid = 1'b0;
    expect_eq("n3_c1_cfg_ready", cfg_ready, 0);
    expect_eq("n3_c1_busy", busy, 1);
    expect_eq("n3_c1_div_enable", div_enable, 1);
    tick();
    expect_eq("n3_c2_div_enable", div_enable, 0);
    expect_eq("n3_c2_div_reset", div_reset, 0);
    expect_eq("n3_c2_div_N", div_N, 1);
    tick();
    expect_eq("n3_c3_div_reset", div_reset, 1);
    expect_eq("n3_c3_div_N", div_N, 3);
    tick();
    expect_eq("n3_c4_div_reset", div_reset, 1);
    expect_eq("n3_c4_update_done", update_done, 0);
    tick();
    expect_eq("n3_c5_update_done", update_done, 1);
    expect_eq("n3_c5_div_reset", div_reset, 0);
    expect_eq("n3_c5_div_enable", div_enable, 0);
    expect_eq("n3_c5_cfg_ready", cfg_ready, 0);
    tick();
    expect_eq("n3_c6_cfg_ready", cfg_ready, 1);
    expect_eq("n3_c6_update_done", update_done, 0);
    expect_eq("n3_c6_div_enable", div_enable, 1);

    // N=5 with div_clk stuck high: forced after WAIT_MAX cycles
    div_clk = 1'b1; cfg_valid = 1'b1; cfg_N = 4'd5;
    tick(); cfg_valid = 1'b0;
    n = 0;
    while (div_enable && n < 40) begin
      n++;
      tick();
    end
    expect_eq("n5_wait_cycles", n, 16);
    tick();
    expect_eq("n5_div_reset", div_reset, 1);
    expect_eq("n5_div_N", div_N, 5);
    tick(); tick();
    expect_eq("n5_update_done", update_done, 1);
    tick();
    expect_eq("n5_cfg_ready", cfg_ready, 1);
    div_clk = 1'b0;

    // N=0 rejected with a single-cycle error pulse
    cfg_valid = 1'b1; cfg_N = 4'd0;
    tick(); cfg_valid = 1'b0;
    expect_eq("n0_cfg_err", cfg_err, 1);
    expect_eq("n0_cfg_ready", cfg_ready, 1);
    expect_eq("n0_busy", busy, 0);
    expect_eq("n0_div_N", div_N, 5);
    expect_eq("n0_div_enable", div_enable, 1);
    tick();
    expect_eq("n0_cfg_err_clear", cfg_err, 0);
    expect_eq("n0_still_idle", busy, 0);

    // N=2 accepted, N=4 held during the update and taken afterwards
    cfg_valid = 1'b1; cfg_N = 4'd2;
    tick(); cfg_N = 4'd4;
    dones = 0; accept_at = -1;
    for (int i = 0; i < 60; i++) begin
      if (i == 2) expect_eq("n2_div_N", div_N, 2);
      if (update_done) dones++;
      if (cfg_ready && !cfg_valid) break;
      if (cfg_ready && cfg_valid) begin
        accept_at = i;
        tick();
        cfg_valid = 1'b0;
      end else begin
        tick();
      end
    end
    expect_eq("n4_accept_cycle", accept_at, 5);
    expect_eq("n4_done_pulses", dones, 2);
    expect_eq("n4_div_N", div_N, 4);
    expect_eq("n4_cfg_ready", cfg_ready, 1);

    // Reset asserted during RESET of an update to N=6
    cfg_valid = 1'b1; cfg_N = 4'd6;
    tick(); cfg_valid = 1'b0;
    tick(); tick();
    expect_eq("n6_in_reset", div_reset, 1);
    expect_eq("n6_div_N_live", div_N, 6);
    #2 reset = 1'b0;
    #1;
    expect_eq("n6_async_div_N", div_N, 1);
    expect_eq("n6_async_div_reset", div_reset, 1);
    expect_eq("n6_async_div_enable", div_enable, 0);
    expect_eq("n6_async_busy", busy, 1);
    @(negedge ref_clk);
    reset = 1'b1;
    dones = 0;
    tick();
    if (update_done) dones++;
    expect_eq("n6_init_div_reset", div_reset, 1);
    tick();
    if (update_done) dones++;
    expect_eq("n6_idle_cfg_ready", cfg_ready, 1);
    expect_eq("n6_idle_div_N", div_N, 1);
    tick(); tick();
    if (update_done) dones++;
    expect_eq("n6_no_done", dones, 0);
    expect_eq("n6_never_applied", div_N, 1);
    expect_eq("n6_idle_busy", busy, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
